// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter: FSM state encoding,
// the default bank width and the round-robin successor function.
package led_arb_pkg;

  typedef enum logic [1:0] {
    LOCKWAIT = 2'd0,
    IDLE     = 2'd1,
    OWN      = 2'd2,
    GAP      = 2'd3
  } led_arb_state_t;

  localparam int LED_W_DEFAULT = 8;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Requester-side bundle of the LED bank arbiter: lock flag, requests,
// per-requester LED images, and the grant/LED/busy results.
interface led_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = 8
);
  logic                       pll_locked;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*LED_W-1:0]   pattern;
  logic [NUM_REQ-1:0]         grant;
  logic [LED_W-1:0]           led;
  logic                       busy;

  modport master (
    output pll_locked, req, pattern,
    input  grant, led, busy
  );

  modport slave (
    input  pll_locked, req, pattern,
    output grant, led, busy
  );
endinterface

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i
// (wrapping modulo NUM_REQ) wins.
module led_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest request is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the LED bank with a minimum hold time, a one-cycle
// break-before-make gap on handoff, and blanking until the PLL is locked.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int LED_W       = LED_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  led_bank_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  led_arb_state_t     state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [HW-1:0]      hold_q, hold_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [LED_W-1:0]   owner_pat;
  logic               others_req;

  led_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    owner_pat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) owner_pat = bus.pattern[i*LED_W +: LED_W];
    end
  end

  assign others_req = |(bus.req & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (!bus.pll_locked) begin
      state_d = LOCKWAIT;
      grant_d = '0;
      led_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        LOCKWAIT: begin
          led_d   = '0;
          state_d = IDLE;
        end
        IDLE, GAP: begin
          state_d = IDLE;
          if (pick_valid) begin
            grant_d = NUM_REQ'(1) << pick_idx;
            owner_d = pick_idx;
            hold_d  = HOLD_LOAD;
            state_d = OWN;
          end
        end
        OWN: begin
          led_d = owner_pat;
          if (hold_q != '0) hold_d = hold_q - 1'b1;
          // Voluntary release wins over hold expiry in the same cycle.
          if (!bus.req[owner_q]) begin
            grant_d = '0;
            ptr_d   = IW'(rr_next(int'(owner_q), NUM_REQ));
            state_d = IDLE;
          end else if (hold_q == '0 && others_req) begin
            grant_d = '0;
            ptr_d   = IW'(rr_next(int'(owner_q), NUM_REQ));
            state_d = GAP;
          end
        end
        default: state_d = LOCKWAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKWAIT;
      grant_q <= '0;
      led_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led   = led_q;
  assign bus.busy  = |grant_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter with 4 requesters and a 4-cycle hold: vector
// table, directed corner sequences, and random traffic against an ownership model.
module tb_led_bank_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam logic [31:0] PAT  = 32'h44_A5_22_11;
  localparam logic [31:0] PATC = 32'h44_3C_22_11;

  logic clk = 1'b0;
  logic rst;

  led_bank_arbiter_if #(.NUM_REQ(N), .LED_W(8)) bus_if ();

  led_bank_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .LED_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Ownership model: who owns the bank, for how many visible cycles, and the
  // round-robin start index; gap and idle look the same from outside.
  int         m_owner;
  int         m_age;
  int         m_ptr;
  bit         m_lw;
  logic [7:0] m_led;

  function automatic bit bit_at(input logic [3:0] v, input int i);
    logic [3:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_ptr   = 0;
    m_lw    = 1'b1;
    m_led   = '0;
  endtask

  task automatic model_step(input logic lk, input logic [3:0] rq, input logic [31:0] pt);
    if (!lk) begin
      m_lw = 1'b1; m_owner = -1; m_age = 0; m_led = '0;
      return;
    end
    if (m_lw) begin
      m_lw = 1'b0; m_led = '0;
      return;
    end
    if (m_owner >= 0) begin
      m_led = 8'(pt >> (8 * m_owner));
      if (!bit_at(rq, m_owner) ||
          (m_age >= HOLD && (rq & ~(4'b0001 << m_owner)) != 4'b0000)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && bit_at(rq, c)) begin
          m_owner = c;
          m_age   = 1;
        end
      end
    end
  endtask

  function automatic logic [3:0] model_grant();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: the model follows the DUT's sampled inputs, then we land on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(bus_if.pll_locked, bus_if.req, bus_if.pattern);
    @(negedge clk);
  endtask

  task automatic drive(input logic lk, input logic [3:0] rq, input logic [31:0] pt);
    bus_if.pll_locked = lk;
    bus_if.req        = rq;
    bus_if.pattern    = pt;
  endtask

  typedef struct {
    logic        lock;
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  grant;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] exp_g;

  initial begin
    vecs[0] = '{1'b0, 4'b1111, PAT,  4'b0000, 8'h00};
    vecs[1] = '{1'b0, 4'b1111, PAT,  4'b0000, 8'h00};
    vecs[2] = '{1'b1, 4'b1111, PAT,  4'b0000, 8'h00};
    vecs[3] = '{1'b1, 4'b1111, PAT,  4'b0001, 8'h00};
    vecs[4] = '{1'b1, 4'b0100, PAT,  4'b0000, 8'h11};
    vecs[5] = '{1'b1, 4'b0100, PAT,  4'b0100, 8'h11};
    vecs[6] = '{1'b1, 4'b0100, PAT,  4'b0100, 8'hA5};
    vecs[7] = '{1'b1, 4'b0100, PATC, 4'b0100, 8'h3C};
    vecs[8] = '{1'b1, 4'b0000, PATC, 4'b0000, 8'h3C};
    vecs[9] = '{1'b1, 4'b0000, PATC, 4'b0000, 8'h3C};

    rst = 1'b1;
    drive(1'b0, 4'b1111, PAT);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_grant", {28'd0, bus_if.grant}, 32'h0);
    check("reset_led",   {24'd0, bus_if.led},   32'h0);
    check("reset_busy",  {31'd0, bus_if.busy},  32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].lock, vecs[i].req, vecs[i].pat);
      tick();
      check($sformatf("vec%0d_grant", i), {28'd0, bus_if.grant}, {28'd0, vecs[i].grant});
      check($sformatf("vec%0d_led", i),   {24'd0, bus_if.led},   {24'd0, vecs[i].led});
    end

    // Two steady requesters alternate with a 4-cycle hold and a 1-cycle gap.
    drive(1'b1, 4'b0011, PAT);
    for (int k = 0; k < 14; k++) begin
      tick();
      exp_g = ((k % 5) == 4) ? 4'b0000 : (((k / 5) % 2) == 1 ? 4'b0010 : 4'b0001);
      check($sformatf("alt%0d_grant", k), {28'd0, bus_if.grant}, {28'd0, exp_g});
    end

    // Owner 0 releases early while requester 3 waits.
    drive(1'b1, 4'b0000, PAT); tick();
    check("idle_grant", {28'd0, bus_if.grant}, 32'h0);
    tick();
    drive(1'b1, 4'b0001, PAT); tick();
    check("own0_c1", {28'd0, bus_if.grant}, 32'h1);
    drive(1'b1, 4'b1001, PAT); tick();
    check("own0_c2", {28'd0, bus_if.grant}, 32'h1);
    drive(1'b1, 4'b1000, PAT); tick();
    check("rel0_grant", {28'd0, bus_if.grant}, 32'h0);
    tick();
    check("own3_grant", {28'd0, bus_if.grant}, 32'h8);
    tick();
    check("own3_led", {24'd0, bus_if.led}, 32'h44);

    // Lock loss mid-ownership blanks the bank; relock resumes from ptr 1.
    drive(1'b0, 4'b1000, PAT); tick();
    check("unlock_grant", {28'd0, bus_if.grant}, 32'h0);
    check("unlock_led",   {24'd0, bus_if.led},   32'h0);
    check("unlock_busy",  {31'd0, bus_if.busy},  32'h0);
    drive(1'b1, 4'b1111, PAT); tick();
    check("relock_wait", {28'd0, bus_if.grant}, 32'h0);
    tick();
    check("relock_grant", {28'd0, bus_if.grant}, 32'h2);
    check("relock_busy",  {31'd0, bus_if.busy},  32'h1);
    tick();
    check("relock_led", {24'd0, bus_if.led}, 32'h22);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("arst_grant", {28'd0, bus_if.grant}, 32'h0);
    check("arst_led",   {24'd0, bus_if.led},   32'h0);
    check("arst_busy",  {31'd0, bus_if.busy},  32'h0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Random traffic against the model.
    drive(1'b1, 4'b0000, PAT);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus_if.pattern = $urandom;
      bus_if.pll_locked = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      tick();
      check("rand_grant", {28'd0, bus_if.grant}, {28'd0, model_grant()});
      check("rand_led",   {24'd0, bus_if.led},   {24'd0, m_led});
      check("rand_busy",  {31'd0, bus_if.busy},  {31'd0, m_owner >= 0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
